// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered 32-bit ALU execute stage with a 2-entry output buffer
// Ports: in_valid/in_ready/in_op/in_a/in_b accept one operation per handshake;
//        out_valid/out_ready/out_result (+ out_zero/out_neg/out_carry/out_ovf) present the oldest result.
// Build option: define ALU_FLAGS_EN to add the status flag ports and per-entry flag storage.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
`ifdef ALU_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  logic [WIDTH-1:0] res;
  assign res = (in_op == 4'd0) ? in_a & in_b :
               (in_op == 4'd1) ? in_a | in_b :
               (in_op == 4'd2) ? in_a ^ in_b :
               (in_op == 4'd3) ? ~(in_a ^ in_b) :
               (in_op == 4'd4) ? ~(in_a & in_b) :
               (in_op == 4'd5) ? ~(in_a | in_b) :
               (in_op == 4'd6) ? in_a + in_b :
               (in_op == 4'd7) ? in_a - in_b :
               (in_op == 4'd8) ? in_a : '0;
`ifdef ALU_FLAGS_EN
  localparam int EW = WIDTH + 4;
  logic carry, ovf;
  // an unsigned add wrapped iff the sum ended up below an addend
  assign carry = (in_op == 4'd6) ? (res < in_a) : (in_op == 4'd7) ? (in_a >= in_b) : 1'b0;
  assign ovf = (in_op == 4'd6) ? (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res[WIDTH-1] != in_a[WIDTH-1]) :
               (in_op == 4'd7) ? (in_a[WIDTH-1] != in_b[WIDTH-1]) && (res[WIDTH-1] != in_a[WIDTH-1]) : 1'b0;
  logic [EW-1:0] new_e;
  assign new_e = {res == '0, res[WIDTH-1], carry, ovf, res};
`else
  localparam int EW = WIDTH;
  logic [EW-1:0] new_e;
  assign new_e = res;
`endif
  state_t state_q, state_d;
  logic [EW-1:0] head_q, head_d, tail_q, tail_d;
  logic push, pop;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  // head_q always holds the oldest entry so outputs come straight from a register
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: if (push) begin
        state_d = ONE;
        head_d  = new_e;
      end
      ONE: if (push && pop) head_d = new_e;
        else if (push) begin
          state_d = FULL;
          tail_d  = new_e;
        end else if (pop) state_d = EMPTY;
      FULL: if (pop) begin
        state_d = ONE;
        head_d  = tail_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end
`ifdef ALU_FLAGS_EN
  assign {out_zero, out_neg, out_carry, out_ovf, out_result} = head_q;
`else
  assign out_result = head_q;
`endif
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage wrapping the 32-bit ALU bitwise/arithmetic functions (AND, OR, XOR, XNOR, NAND, NOR, ADD, SUB, PASS). Sits between operand fetch and writeback: accepts an opcode plus two operands on a valid/ready handshake, computes the result and status flags, and holds them in a 2-entry output buffer. Absorbs writeback backpressure without dropping or reordering results.

## Interface
- WIDTH, 32, operand/result width in bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  stage can accept; depends only on registered state
- in_op  input  4  opcode
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  head buffer entry valid
- out_ready  input  1  consumer accepts head entry
- out_result  output  WIDTH  head result
- out_zero, out_neg, out_carry, out_ovf  output  1 each  head flags (present only with ALU_FLAGS_EN)

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 XNOR (~(A^B)), 4 NAND, 5 NOR, 6 ADD, 7 SUB (A-B), 8 PASS A; 9-15 illegal -> result 0.
- All arithmetic modulo 2^WIDTH; no sign extension; result truncated to WIDTH.
- Flags computed from the result being stored: zero = (result==0); neg = result[WIDTH-1].
- carry: ADD -> carry-out of bit WIDTH-1; SUB -> 1 when A>=B unsigned (no borrow); all other ops 0.
- ovf: ADD -> A,B same sign and result sign differs; SUB -> A,B signs differ and result sign differs from A; others 0.
- Push: in_valid & in_ready at a rising edge; result and flags computed combinationally from in_* and written to buffer tail that edge.
- Pop: out_valid & out_ready at a rising edge; head entry retired.
- Buffer states by occupancy: EMPTY (0), ONE (1), FULL (2).
  - EMPTY: push -> ONE; out_valid=0.
  - ONE: push only -> FULL; pop only -> EMPTY; push+pop same edge -> ONE, new entry becomes head.
  - FULL: in_ready=0, no push; pop -> ONE.
- in_ready = (state != FULL). out_valid = (state != EMPTY).
- out_* fields stable while out_valid=1 and out_ready=0.
- Strict FIFO order; no entry lost or duplicated.

## Timing
- Reset (async assert, sync-to-clk release): state EMPTY, out_valid 0, in_ready 1, out_result 0, all flags 0, buffer contents 0.
- Reset mid-operation: buffered entries discarded immediately; out_valid falls without waiting for clk.
- Latency: push at edge N into EMPTY -> out_valid=1 with that result after edge N.
- Throughput: 1 op/cycle sustained while out_ready held 1.
- FULL -> pop at edge N -> in_ready=1 after edge N; earliest next push at edge N+1.
- No combinational path from out_ready to in_ready, nor from in_* to out_*.

## Configuration
- ALU_FLAGS_EN defined: out_zero/out_neg/out_carry/out_ovf ports exist; flags stored per buffer entry and presented with head result.
- ALU_FLAGS_EN undefined: flag ports and flag storage removed; result path, handshake, and latency unchanged.

## Test plan
- Reset then XNOR A=0xAAAAAAAA B=0xDDDDDDDD, out_ready=1 -> out_valid one cycle later, out_result=0x88888888, zero=0, neg=1, carry=0, ovf=0.
- XNOR A=0x000000AA B=0x000000AB -> 0xFFFFFFFE; XNOR A=B=0 -> 0xFFFFFFFF; back-to-back pushes produce results on consecutive cycles.
- ADD 0xFFFFFFFF+0x00000001 -> 0x00000000, zero=1, carry=1, ovf=0; ADD 0x7FFFFFFF+1 -> 0x80000000, neg=1, ovf=1; SUB 5-7 -> 0xFFFFFFFE, neg=1, carry=0.
- out_ready=0, push AND, OR, XOR with in_valid held -> first two accepted, in_ready=0 after second, third held; raise out_ready -> results emerge in order AND, OR, XOR, one per cycle.
- Buffer FULL, pulse rst_n low between edges -> out_valid=0 and out_result=0 immediately; after release in_ready=1, no stale entries.
- Opcode 12 with A=0x12345678 -> out_result=0, zero=1, other flags 0; build without ALU_FLAGS_EN -> same result sequence for all prior scenarios.
